// File: rtl/ddr3_pkg.sv
// Shared state type and default sizes for the DDR3 port arbiter slice.
package ddr3_pkg;

  localparam int unsigned DDR3_ADDR_W = 18;
  localparam int unsigned DDR3_DATA_W = 16;
  localparam int unsigned MAX_NUM_OF_REFRESH_COMMANDS_POSTPONED = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ddr3_port_arbiter_if.sv
// User request/response and memory-controller command bundle of the arbiter.
// master = requesters plus controller side, slave = arbiter.
interface ddr3_port_arbiter_if
  import ddr3_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = DDR3_ADDR_W,
  parameter int unsigned DATA_W    = DDR3_DATA_W
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        ctrl_write_enable;
  logic                        ctrl_read_enable;
  logic [ADDR_W-1:0]           ctrl_address;
  logic [DATA_W-1:0]           ctrl_wdata;
  logic                        ctrl_ready;
  logic                        ctrl_rd_valid;
  logic [DATA_W-1:0]           ctrl_rdata;
  logic [3:0]                  extra_cycles;
  logic                        tag_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ctrl_ready, ctrl_rd_valid, ctrl_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ctrl_write_enable, ctrl_read_enable,
           ctrl_address, ctrl_wdata, extra_cycles, tag_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ctrl_ready, ctrl_rd_valid, ctrl_rdata,
    output req_ready, rsp_valid, rsp_rdata, ctrl_write_enable, ctrl_read_enable,
           ctrl_address, ctrl_wdata, extra_cycles, tag_err
  );

endinterface

// File: rtl/ddr3_tag_fifo.sv
// Synchronous FIFO of port IDs for outstanding reads; push and pop in the same
// cycle always both proceed (bypass when empty, overwrite-after-read when full).
module ddr3_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] pop_tag,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & (~empty | push);
  assign do_push = push & (~full | pop);
  assign pop_tag = empty ? push_tag : mem[rptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_tag;
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Multi-port command arbiter in front of a DDR3 controller with read-tag routing.
// Build option DDR3_ARB_FIXED_PRIORITY_EN: strict lowest-index priority instead of round-robin.
module ddr3_port_arbiter
  import ddr3_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned ADDR_W          = DDR3_ADDR_W,
  parameter int unsigned DATA_W          = DDR3_DATA_W,
  parameter int unsigned MAX_GRANT_BEATS = MAX_NUM_OF_REFRESH_COMMANDS_POSTPONED,
  parameter int unsigned TAG_DEPTH       = 8
) (
  input logic                clk,
  input logic                resetn,
  ddr3_port_arbiter_if.slave bus
);
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BEAT_W = 4;

  arb_state_e          state, state_nxt;
  logic [PORT_W-1:0]   grant, grant_nxt, last, last_nxt, winner, idx;
  logic [BEAT_W-1:0]   beats, beats_nxt;
  logic [NUM_PORTS-1:0] ready;
  logic                accept, accept_rd;
  logic                tag_full, tag_empty, tag_pop;
  logic [PORT_W-1:0]   tag_out;

  assign bus.req_ready    = ready;
  assign bus.extra_cycles = 4'(MAX_GRANT_BEATS);
  assign accept           = |ready;
  assign accept_rd        = accept & ~bus.req_write[grant];
  assign tag_pop          = bus.ctrl_rd_valid & (~tag_empty | accept_rd);

  // Winner pick; reverse scan so the candidate closest to the start point wins.
  always_comb begin
    winner = '0;
    idx    = '0;
`ifdef DDR3_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = PORT_W'(i);
      if (bus.req_valid[idx]) winner = idx;
    end
`else
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = PORT_W'((int'(last) + i) % NUM_PORTS);
      if (bus.req_valid[idx]) winner = idx;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    beats_nxt = beats;
    ready     = '0;
    case (state)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          grant_nxt = winner;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        ready[grant] = bus.ctrl_ready & bus.req_valid[grant]
                     & ~(~bus.req_write[grant] & tag_full);
        if (ready[grant]) beats_nxt = beats + BEAT_W'(1);
        if ((beats_nxt == BEAT_W'(MAX_GRANT_BEATS)) || !bus.req_valid[grant])
          state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        last_nxt  = grant;
        beats_nxt = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= PORT_W'(NUM_PORTS - 1);
      beats <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      beats <= beats_nxt;
    end
  end

  // Command issue and read-return routing, one cycle behind their triggers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.ctrl_write_enable <= 1'b0;
      bus.ctrl_read_enable  <= 1'b0;
      bus.ctrl_address      <= '0;
      bus.ctrl_wdata        <= '0;
      bus.rsp_valid         <= '0;
      bus.rsp_rdata         <= '0;
      bus.tag_err           <= 1'b0;
    end else begin
      bus.ctrl_write_enable <= accept & bus.req_write[grant];
      bus.ctrl_read_enable  <= accept_rd;
      if (accept) begin
        bus.ctrl_address <= bus.req_addr[grant*ADDR_W +: ADDR_W];
        bus.ctrl_wdata   <= bus.req_wdata[grant*DATA_W +: DATA_W];
      end
      bus.rsp_valid <= tag_pop ? (NUM_PORTS'(1) << tag_out) : '0;
      if (tag_pop) bus.rsp_rdata <= bus.ctrl_rdata;
      if (bus.ctrl_rd_valid & ~tag_pop) bus.tag_err <= 1'b1;
    end
  end

  ddr3_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .TAG_W (PORT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept_rd),
    .push_tag (grant),
    .pop      (bus.ctrl_rd_valid),
    .pop_tag  (tag_out),
    .full     (tag_full),
    .empty    (tag_empty)
  );

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Self-checking bench for ddr3_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_ddr3_port_arbiter;
  localparam int unsigned NP = 2, AW = 18, DW = 16, MAXB = 8, TD = 8;
  localparam int unsigned AWT = NP * AW, DWT = NP * DW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ddr3_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ddr3_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_GRANT_BEATS(MAXB), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ctrl_ready = 1'b0; bus.ctrl_rd_valid = 1'b0; bus.ctrl_rdata = '0;
  endtask

  // Ends at negedge+1 with reset released; the next posedge is the first live one.
  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_inputs();
    @(negedge clk); #1;
    check("rst_flags", {bus.req_ready, bus.rsp_valid, bus.ctrl_write_enable,
                        bus.ctrl_read_enable, bus.tag_err}, '0);
    check("rst_fields", {bus.ctrl_address, bus.ctrl_wdata, bus.rsp_rdata}, '0);
    resetn = 1'b1;
  endtask

  // Holds one command on port p until it is accepted, then drops valid.
  task automatic do_cmd(input logic p, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bit done = 0;
    bus.req_valid[p] = 1'b1;
    bus.req_write[p] = wr;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_wdata[p*DW +: DW] = d;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (bus.req_ready[p]) done = 1;
      @(negedge clk);
    end
    bus.req_valid[p] = 1'b0;
    check("cmd_accepted", done, 1);
  endtask

  task automatic do_return(input logic [DW-1:0] d, input logic [NP-1:0] exp_v);
    bus.ctrl_rd_valid = 1'b1;
    bus.ctrl_rdata = d;
    @(negedge clk);
    bus.ctrl_rd_valid = 1'b0;
    #1;
    check("ret_route", bus.rsp_valid, exp_v);
    check("ret_data", bus.rsp_rdata, d);
    @(negedge clk);
  endtask

  typedef struct {
    logic [NP-1:0] v, w; logic [AW-1:0] a0; logic [DW-1:0] d0; logic cr;
    logic [NP-1:0] ready; logic we, re; logic [AW-1:0] addr; logic [DW-1:0] wdata;
  } vec_t;
  vec_t tbl[7];

  // Reference model: who owns the bus, whether a hand-over gap is pending,
  // and the in-order list of ports awaiting read data.
  int owner, last, beats;
  bit cooling;
  int tagq[$];
  logic we_e, re_e, err_e;
  logic [AW-1:0] addr_e;
  logic [DW-1:0] wd_e, rd_e;
  logic [NP-1:0] rsp_e, rdy_e;

  function automatic int rr_pick(input logic [NP-1:0] v, input int from);
    for (int k = 1; k <= NP; k++) begin
      int c = (from + k) % NP;
      if (((v >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; last = NP - 1; beats = 0; cooling = 0; tagq.delete();
    we_e = 0; re_e = 0; err_e = 0; addr_e = '0; wd_e = '0; rd_e = '0; rsp_e = '0;
  endtask

  task automatic model_step();
    bit acc, rd, bypass;
    int g;
    g = owner;
    acc = (rdy_e != 0);
    rd = acc && (((bus.req_write >> g) & 1) == 0);
    we_e = acc && !rd;
    re_e = rd;
    if (acc) begin
      addr_e = AW'(bus.req_addr >> (g * AW));
      wd_e = DW'(bus.req_wdata >> (g * DW));
    end
    rsp_e = '0;
    bypass = 0;
    if (bus.ctrl_rd_valid) begin
      if (tagq.size() > 0) begin
        rsp_e = NP'(1) << tagq.pop_front();
        rd_e = bus.ctrl_rdata;
      end else if (rd) begin
        rsp_e = NP'(1) << g;
        rd_e = bus.ctrl_rdata;
        bypass = 1;
      end else err_e = 1;
    end
    if (rd && !bypass) tagq.push_back(g);
    if (owner < 0) owner = rr_pick(bus.req_valid, last);
    else if (cooling) begin last = owner; owner = -1; beats = 0; cooling = 0; end
    else begin
      beats += int'(acc);
      if (beats == MAXB || ((bus.req_valid >> owner) & 1) == 0) cooling = 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, extra, both;
    bit got;
    logic [NP-1:0] first, nv;
    int seq[$], runs_p[$], runs_n[$];

    // Port 0 issues three writes then goes idle.
    tbl[0] = '{2'b01, 2'b01, 18'd0, 16'd0, 1'b1, 2'b00, 1'b0, 1'b0, 18'd0, 16'd0};
    tbl[1] = '{2'b01, 2'b01, 18'd0, 16'd1, 1'b1, 2'b01, 1'b0, 1'b0, 18'd0, 16'd0};
    tbl[2] = '{2'b01, 2'b01, 18'd1, 16'd2, 1'b1, 2'b01, 1'b1, 1'b0, 18'd0, 16'd1};
    tbl[3] = '{2'b01, 2'b01, 18'd2, 16'd3, 1'b1, 2'b01, 1'b1, 1'b0, 18'd1, 16'd2};
    tbl[4] = '{2'b00, 2'b01, 18'd2, 16'd3, 1'b1, 2'b00, 1'b1, 1'b0, 18'd2, 16'd3};
    tbl[5] = '{2'b00, 2'b00, 18'd0, 16'd0, 1'b1, 2'b00, 1'b0, 1'b0, 18'd2, 16'd3};
    tbl[6] = '{2'b00, 2'b00, 18'd0, 16'd0, 1'b1, 2'b00, 1'b0, 1'b0, 18'd2, 16'd3};

    clear_inputs();
    apply_reset();
    check("extra_cycles", bus.extra_cycles, MAXB);
    for (int r = 0; r < 7; r++) begin
      bus.req_valid = tbl[r].v; bus.req_write = tbl[r].w;
      bus.req_addr[AW-1:0] = tbl[r].a0; bus.req_wdata[DW-1:0] = tbl[r].d0;
      bus.ctrl_ready = tbl[r].cr;
      #1;
      check($sformatf("tbl%0d_ready", r), bus.req_ready, tbl[r].ready);
      check($sformatf("tbl%0d_en", r), {bus.ctrl_write_enable, bus.ctrl_read_enable},
            {tbl[r].we, tbl[r].re});
      check($sformatf("tbl%0d_addr", r), bus.ctrl_address, tbl[r].addr);
      check($sformatf("tbl%0d_wdata", r), bus.ctrl_wdata, tbl[r].wdata);
      @(negedge clk);
    end

    // Both ports saturated: grants alternate in blocks of MAXB.
    apply_reset();
    bus.req_valid = 2'b11; bus.req_write = 2'b11; bus.ctrl_ready = 1'b1;
    both = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.req_ready == 2'b11) both++;
      else if (bus.req_ready != 0) seq.push_back(bus.req_ready[1] ? 1 : 0);
      @(negedge clk);
    end
    foreach (seq[i]) begin
      if (i > 0 && seq[i] == seq[i-1]) runs_n[runs_n.size()-1] += 1;
      else begin runs_p.push_back(seq[i]); runs_n.push_back(1); end
    end
    check("rr_both_ready", both, 0);
    check("rr_enough_runs", runs_p.size() >= 4, 1);
    for (int i = 0; i < 4 && i < runs_p.size(); i++) begin
      check($sformatf("rr_run%0d_port", i), runs_p[i], i % 2);
      check($sformatf("rr_run%0d_len", i), runs_n[i], MAXB);
    end

    // Tag FIFO full: reads stall, writes pass, returns all route to port 1.
    apply_reset();
    bus.req_valid = 2'b10; bus.req_write = 2'b00; bus.ctrl_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      #1;
      if (bus.req_ready[1]) acc++;
      @(negedge clk);
    end
    check("full_reads_accepted", acc, 8);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.req_ready != 0) extra++;
      @(negedge clk);
    end
    check("full_blocks_read", extra, 0);
    bus.req_write = 2'b10;
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      #1;
      if (bus.req_ready == 2'b10) got = 1;
      @(negedge clk);
    end
    check("full_write_ok", got, 1);
    bus.req_valid = '0; bus.req_write = '0;
    for (int k = 0; k < 8; k++) do_return(DW'(16'h0100 + k), 2'b10);
    check("full_no_err", bus.tag_err, 0);

    // Interleaved reads from both ports return in issue order.
    apply_reset();
    bus.ctrl_ready = 1'b1;
    do_cmd(1'b0, 1'b0, 18'h00011, 16'h0);
    do_cmd(1'b1, 1'b0, 18'h00022, 16'h0);
    repeat (2) @(negedge clk);
    do_return(16'hA5A5, 2'b01);
    do_return(16'h5A5A, 2'b10);

    // Return with nothing outstanding sets a sticky error.
    apply_reset();
    bus.ctrl_rd_valid = 1'b1; bus.ctrl_rdata = 16'h1234;
    @(negedge clk);
    bus.ctrl_rd_valid = 1'b0;
    #1;
    check("err_set", bus.tag_err, 1);
    check("err_no_rsp", bus.rsp_valid, 0);
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", bus.tag_err, 1);
    apply_reset();

    // Reset mid-grant with three reads outstanding.
    bus.ctrl_ready = 1'b1;
    do_cmd(1'b0, 1'b0, 18'h00100, 16'h0);
    bus.req_valid = 2'b01; bus.req_write = 2'b00;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      #1;
      if (bus.req_ready[0]) acc++;
      @(negedge clk);
    end
    check("mid_reads", acc, 2);
    bus.req_valid = 2'b11; bus.req_write = 2'b11;
    resetn = 1'b0;
    @(negedge clk); #1;
    check("mr_flags", {bus.req_ready, bus.rsp_valid, bus.ctrl_write_enable,
                       bus.ctrl_read_enable, bus.tag_err}, '0);
    check("mr_fields", {bus.ctrl_address, bus.ctrl_wdata, bus.rsp_rdata}, '0);
    resetn = 1'b1;
    first = '0;
    for (int c = 0; c < 10 && first == 0; c++) begin
      @(negedge clk); #1;
      first = bus.req_ready;
    end
    check("mr_first_port0", first, 2'b01);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    bus.ctrl_rd_valid = 1'b1;
    @(negedge clk);
    bus.ctrl_rd_valid = 1'b0;
    #1;
    check("mr_tags_dropped", bus.tag_err, 1);

    // Randomized traffic against the reference model.
    apply_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      nv = (bus.req_valid & ~(NP'($urandom) & NP'($urandom) & NP'($urandom)))
         | (~bus.req_valid & NP'($urandom) & NP'($urandom));
      bus.req_valid = nv;
      bus.req_write = NP'($urandom);
      bus.req_addr = AWT'({$urandom(), $urandom()});
      bus.req_wdata = DWT'($urandom());
      bus.ctrl_ready = ($urandom_range(3) != 0);
      bus.ctrl_rd_valid = (tagq.size() > 0) && ($urandom_range(2) == 0);
      bus.ctrl_rdata = DW'($urandom());
      #1;
      check("rnd_en", {bus.ctrl_write_enable, bus.ctrl_read_enable}, {we_e, re_e});
      check("rnd_addr", bus.ctrl_address, addr_e);
      check("rnd_wdata", bus.ctrl_wdata, wd_e);
      check("rnd_rsp", bus.rsp_valid, rsp_e);
      if (rsp_e != 0) check("rnd_rdata", bus.rsp_rdata, rd_e);
      check("rnd_err", bus.tag_err, err_e);
      rdy_e = '0;
      if (owner >= 0 && !cooling && bus.ctrl_ready && ((bus.req_valid >> owner) & 1) != 0
          && (((bus.req_write >> owner) & 1) != 0 || tagq.size() < TD))
        rdy_e = NP'(1) << owner;
      check("rnd_ready", bus.req_ready, rdy_e);
      model_step();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_port_arbiter.md
DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 NUM_PORTS, 2, number of user requesters (2..4).
REQ-002 ADDR_W, 18, bank+row/column address width (3+15).
REQ-003 DATA_W, 16, DQ data width.
REQ-004 MAX_GRANT_BEATS, 8, max commands per grant; equals the controller's refresh-postponement budget.
REQ-005 TAG_DEPTH, 8, outstanding-read tag FIFO depth (power of 2).

Ports (name, direction, width, meaning):
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 resetn  in  1  synchronous, active-low reset.
REQ-008 req_valid  in  NUM_PORTS  per-port command valid.
REQ-009 req_write  in  NUM_PORTS  per-port 1=write, 0=read.
REQ-010 req_addr  in  NUM_PORTS*ADDR_W  per-port address, port p at slice p.
REQ-011 req_wdata  in  NUM_PORTS*DATA_W  per-port write data.
REQ-012 req_ready  out  NUM_PORTS  per-port command accepted this cycle when valid&ready.
REQ-013 rsp_valid  out  NUM_PORTS  one-cycle read-return strobe to owning port.
REQ-014 rsp_rdata  out  DATA_W  read data, shared by all ports.
REQ-015 ctrl_write_enable, ctrl_read_enable  out  1 each  command pulses to memory controller.
REQ-016 ctrl_address  out  ADDR_W; ctrl_wdata  out  DATA_W  registered command fields.
REQ-017 ctrl_ready  in  1  controller can accept a command this cycle.
REQ-018 ctrl_rd_valid  in  1; ctrl_rdata  in  DATA_W  read data returned in issue order.
REQ-019 extra_cycles  out  4  user_desired_extra_read_or_write_cycles for controller, constant MAX_GRANT_BEATS.
REQ-020 tag_err  out  1  sticky: ctrl_rd_valid seen with tag FIFO empty.

Function
REQ-021 FSM states IDLE, GRANT, SWITCH; encoding 2 bits.
REQ-022 IDLE: any req_valid -> select winner, GRANT next cycle; none -> stay.
REQ-023 Winner selection: round-robin starting at port after last-granted; ties resolved by lowest index from pointer.
REQ-024 GRANT: req_ready[g] = ctrl_ready & req_valid[g] & ~(~req_write[g] & tag_full); all other req_ready = 0.
REQ-025 Accepted command: ctrl_*_enable, ctrl_address, ctrl_wdata registered, asserted exactly one cycle after acceptance, one-cycle pulse; never both enables high.
REQ-026 No acceptance cycle: both enables 0; ctrl_address/ctrl_wdata hold last value.
REQ-027 Beat counter (4 bits) increments per acceptance; reaching MAX_GRANT_BEATS, or req_valid[g] low in GRANT, -> SWITCH.
REQ-028 SWITCH: one bubble cycle; pointer := g; counter := 0; -> IDLE.
REQ-029 Accepted read pushes port ID into tag FIFO; tag_full blocks further reads (writes still proceed).
REQ-030 ctrl_rd_valid pops tag FIFO; rsp_valid[tag]=1 and rsp_rdata=ctrl_rdata one cycle later.
REQ-031 Simultaneous push and pop with FIFO full or empty: both proceed; occupancy unchanged.
REQ-032 ctrl_rd_valid with FIFO empty: no pop, no rsp_valid, tag_err set until reset.
REQ-033 FIFO pointers wrap modulo TAG_DEPTH; occupancy counter width clog2(TAG_DEPTH)+1.

Reset
REQ-034 resetn low at clk edge: state IDLE, pointer to last port (port 0 wins first), counter 0, FIFO empty, tag_err 0.
REQ-035 Outputs during/after reset: req_ready 0, rsp_valid 0, rsp_rdata 0, ctrl enables 0, ctrl_address 0, ctrl_wdata 0.
REQ-036 Reset mid-grant or with reads outstanding discards all tags; later ctrl_rd_valid sets tag_err.

Configuration
REQ-037 Macro DDR3_ARB_FIXED_PRIORITY_EN defined: selection is strict priority, lowest index wins, pointer ignored; undefined: round-robin per REQ-023.

Structure
REQ-038 Shared package ddr3_pkg: FSM state typedef, ADDR_W/DATA_W defaults, MAX_NUM_OF_REFRESH_COMMANDS_POSTPONED (8).
REQ-039 One sub-module: ddr3_tag_fifo (synchronous FIFO of port IDs, push/pop/full/empty).

Verification
REQ-040 Port 0 issues 3 writes, addr 0..2, data 1..3 -> ctrl_write_enable pulses 3 cycles, each one cycle after acceptance, matching fields.
REQ-041 Both ports hold valid continuously -> grants alternate P0,P1, each exactly 8 commands, one SWITCH bubble between.
REQ-042 P1 issues 8 reads, ctrl_rd_valid withheld -> 9th read req_ready 0; a write still accepted; returns route 8 rsp_valid[1] in order.
REQ-043 Interleaved reads P0/P1, returns data 0xA5A5,0x5A5A -> rsp_valid[0] then rsp_valid[1] with matching data.
REQ-044 ctrl_rd_valid pulse with FIFO empty -> tag_err=1, holds until resetn low.
REQ-045 resetn low mid-grant with 3 reads outstanding -> all outputs zero next cycle; first grant after release to port 0.
